pre_if_stage: RTL
=================

# pre_if_stage

Pre-IF stage of the five-stage LoongArch pipeline, directly upstream of `if_stage`. It owns the fetch PC and selects the next fetch address: sequential, branch target or exception/ertn redirect. It issues requests on a req/addr_ok instruction-SRAM interface and hands each accepted fetch (valid + PC) to IF. Redirects that arrive while a request cannot be withdrawn are buffered, and IF is told to drop the stale instruction.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fs_allowin  in  1  IF can accept a new fetch this cycle.
- br_bus  in  33  {br_taken, br_target[31:0]} from ID. br_taken is a single-cycle pulse.
- ex_flush  in  1  exception/ertn redirect pulse from WB.
- ex_target  in  32  redirect PC, valid with ex_flush.
- inst_sram_req  out  1  fetch request.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'd2 (word).
- inst_sram_addr  out  32  fetch address.
- inst_sram_addr_ok  in  1  request accepted this cycle (handshake = req && addr_ok).
- to_fs_valid  out  1  a valid fetch is handed to IF this cycle.
- to_fs_pc  out  32  PC of that fetch.
- fs_cancel  out  1  1-cycle pulse: IF must discard the data of the fetch accepted this cycle.

## Operation
- Registers:
  - pc_r: last issued PC.
  - redir_v/redir_pc: buffered redirect.
  - hold_addr: address of a pending request.
  - stale: pending request is on the wrong path.
  - state.
- Next-address priority, computed combinationally in REQ: ex_flush ? ex_target : br_taken ? br_target : redir_v ? redir_pc : pc_r + 4.
  - pc_r + 4 wraps modulo 2^32.
  - Target bits [1:0] pass through unchanged; alignment is checked downstream.
- States:
  - IDLE: entered on reset; req=0. Moves to REQ the next cycle.
  - REQ:
    - req = fs_allowin; addr = next-address.
    - If req && addr_ok: pc_r <= addr, redir_v <= 0, to_fs_valid=1, to_fs_pc=addr, stay in REQ.
    - If req && !addr_ok: hold_addr <= addr, stale <= 0, go to HOLD.
  - HOLD:
    - req=1; addr=hold_addr (stable until accepted).
    - A br_taken or ex_flush here sets stale <= 1 and loads redir_pc. If both occur in the same cycle, ex_target wins.
    - On addr_ok with stale=0: pc_r <= hold_addr. If fs_allowin, to_fs_valid=1 and return to REQ; otherwise go to PEND.
    - On addr_ok with stale=1: to_fs_valid=0, fs_cancel=1, redir_v <= 1, return to REQ. pc_r is not updated.
  - PEND:
    - req=0; waits for fs_allowin, then to_fs_valid=1, to_fs_pc=pc_r, returns to REQ.
    - A redirect here: fs_cancel=1 in that cycle, no to_fs_valid, redir_v <= 1, go to REQ.
- Redirect arriving in REQ in a cycle with no handshake: loads redir_v/redir_pc so it is not lost.
- A later redirect overwrites an earlier buffered one.
- ex_flush always overrides br_taken and any buffered target.

## Timing
- Reset values:
  - state = IDLE, pc_r = RESET_PC-4, redir_v = 0, stale = 0.
  - All outputs 0 except inst_sram_size = 2.
- The first request is issued in the cycle after reset deasserts, with addr = RESET_PC.
- Zero-latency address select: a redirect pulse in REQ appears on inst_sram_addr in the same cycle.
- Back-to-back: with addr_ok and fs_allowin held at 1, there is one fetch per cycle.
- inst_sram_req and inst_sram_addr never change between req rising and addr_ok.
- to_fs_valid and fs_cancel are mutually exclusive and each lasts 1 cycle per fetch.
- Reset mid-HOLD abandons the request: req drops the following cycle, with no cancel pulse.

## Test plan
- Reset release, addr_ok=1, fs_allowin=1 → addrs 1c000000, 1c000004, 1c000008 on consecutive cycles; to_fs_valid=1 each cycle.
- br_taken pulse, target 1c000100, in REQ with addr_ok=1 → same-cycle addr 1c000100; next addr 1c000104.
- addr_ok=0 for 3 cycles at addr 1c000008, br_taken 1c000200 in cycle 2 → addr stays 1c000008 until addr_ok. Then fs_cancel=1 with to_fs_valid=0, and the next request is 1c000200.
- br_taken and ex_flush in the same HOLD cycle (targets 1c000300 and 1c008000) → after cancel, the next addr is 1c008000.
- addr_ok in HOLD with fs_allowin=0 for 2 cycles → to_fs_valid delayed to the cycle fs_allowin rises, to_fs_pc = held addr; req=0 meanwhile.
- pc_r = ffff_fffc, sequential fetch → next addr 0000_0000.

Source files
------------

// File: rtl/pre_if_stage.sv
// Pre-IF stage: owns the fetch PC, selects the next fetch address and drives the
// req/addr_ok instruction-SRAM request, buffering redirects that hit a pending request.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic [32:0] br_bus,
    input  logic        ex_flush,
    input  logic [31:0] ex_target,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    output logic        to_fs_valid,
    output logic [31:0] to_fs_pc,
    output logic        fs_cancel
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_PEND} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        redir_v_q, redir_v_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic        stale_q, stale_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect;
    logic [31:0] redir_tgt;
    logic [31:0] next_addr;

    assign br_taken       = br_bus[32];
    assign br_target      = br_bus[31:0];
    assign redirect       = ex_flush | br_taken;
    assign redir_tgt      = ex_flush ? ex_target : br_target;
    assign next_addr      = ex_flush  ? ex_target  :
                            br_taken  ? br_target  :
                            redir_v_q ? redir_pc_q : pc_q + 32'd4;
    assign inst_sram_wr   = 1'b0;
    assign inst_sram_size = 2'd2;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        redir_v_d      = redir_v_q;
        redir_pc_d     = redir_pc_q;
        hold_addr_d    = hold_addr_q;
        stale_d        = stale_q;
        inst_sram_req  = 1'b0;
        inst_sram_addr = '0;
        to_fs_valid    = 1'b0;
        to_fs_pc       = '0;
        fs_cancel      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                inst_sram_req  = fs_allowin;
                inst_sram_addr = next_addr;
                if (fs_allowin) begin
                    // The issued address already absorbs any buffered redirect, so it is consumed either way.
                    redir_v_d = 1'b0;
                    if (inst_sram_addr_ok) begin
                        pc_d        = next_addr;
                        to_fs_valid = 1'b1;
                        to_fs_pc    = next_addr;
                    end else begin
                        hold_addr_d = next_addr;
                        stale_d     = 1'b0;
                        state_d     = S_HOLD;
                    end
                end else if (redirect) begin
                    redir_v_d  = 1'b1;
                    redir_pc_d = redir_tgt;
                end
            end
            S_HOLD: begin
                inst_sram_req  = 1'b1;
                inst_sram_addr = hold_addr_q;
                if (redirect) begin
                    stale_d    = 1'b1;
                    redir_pc_d = redir_tgt;
                end
                if (inst_sram_addr_ok) begin
                    if (stale_q || redirect) begin
                        fs_cancel = 1'b1;
                        redir_v_d = 1'b1;
                        stale_d   = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        pc_d = hold_addr_q;
                        if (fs_allowin) begin
                            to_fs_valid = 1'b1;
                            to_fs_pc    = hold_addr_q;
                            state_d     = S_REQ;
                        end else begin
                            state_d = S_PEND;
                        end
                    end
                end
            end
            S_PEND: begin
                if (redirect) begin
                    fs_cancel  = 1'b1;
                    redir_v_d  = 1'b1;
                    redir_pc_d = redir_tgt;
                    state_d    = S_REQ;
                end else if (fs_allowin) begin
                    to_fs_valid = 1'b1;
                    to_fs_pc    = pc_q;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC - 32'd4;
            redir_v_q   <= 1'b0;
            redir_pc_q  <= '0;
            hold_addr_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_v_q   <= redir_v_d;
            redir_pc_q  <= redir_pc_d;
            hold_addr_q <= hold_addr_d;
            stale_q     <= stale_d;
        end
    end

endmodule
